// File: rtl/time_set_pkg.sv
// Shared encodings for the alarm-clock time-set controller: mode values and
// auto-repeat phases, plus the mode-advance helper.
package time_set_pkg;

    typedef enum logic [1:0] {
        MODE_RUN    = 2'd0,
        MODE_SET_A0 = 2'd1,
        MODE_SET_A1 = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_DELAY  = 2'd1,
        PH_REPEAT = 2'd2
    } phase_e;

    function automatic mode_e next_mode(input mode_e cur);
        mode_e nxt;
        case (cur)
            MODE_RUN:    nxt = MODE_SET_A0;
            MODE_SET_A0: nxt = MODE_SET_A1;
            MODE_SET_A1: nxt = MODE_RUN;
            default:     nxt = MODE_RUN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/time_set_controller_auto_repeat.sv
// Hold-to-repeat engine for one adjust button: merges the press pulse with
// delayed and periodic repeat strobes into a single event pulse.
module auto_repeat
    import time_set_pkg::*;
#(
    parameter int REPEAT_DELAY = 24,
    parameter int REPEAT_RATE  = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic press,
    input  logic held,
    input  logic rep_tick,
    input  logic flush,
    output logic evt
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] DELAY_C = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RATE_C  = CW'(REPEAT_RATE);
    localparam logic [CW-1:0] SAT_C   = {CW{1'b1}};
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

    phase_e        phase_r;
    phase_e        phase_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [CW-1:0] cnt_inc_s;
    logic          delay_hit_s;
    logic          rate_hit_s;
    logic          strobe_s;

    // Strobe is kept independent of flush so the mode logic can depend on it without a loop.
    assign cnt_inc_s   = (cnt_r == SAT_C) ? cnt_r : (cnt_r + ONE_C);
    assign delay_hit_s = (phase_r == PH_DELAY)  && (cnt_inc_s >= DELAY_C);
    assign rate_hit_s  = (phase_r == PH_REPEAT) && (cnt_inc_s >= RATE_C);
    assign strobe_s    = held && rep_tick && !press && (delay_hit_s || rate_hit_s);
    assign evt         = press || strobe_s;

    // Next phase/count: flush beats press, press beats release, release beats ticking.
    always_comb begin
        phase_s = phase_r;
        cnt_s   = cnt_r;
        if (flush) begin
            phase_s = PH_IDLE;
            cnt_s   = ZERO_C;
        end else if (press) begin
            phase_s = PH_DELAY;
            cnt_s   = ZERO_C;
        end else if (!held) begin
            phase_s = PH_IDLE;
            cnt_s   = ZERO_C;
        end else if (rep_tick) begin
            case (phase_r)
                PH_DELAY: begin
                    if (delay_hit_s) begin
                        phase_s = PH_REPEAT;
                        cnt_s   = ZERO_C;
                    end else begin
                        cnt_s   = cnt_inc_s;
                    end
                end
                PH_REPEAT: begin
                    if (rate_hit_s) begin
                        cnt_s = ZERO_C;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                PH_IDLE: begin
                    cnt_s = ZERO_C;
                end
                default: begin
                    phase_s = PH_IDLE;
                    cnt_s   = ZERO_C;
                end
            endcase
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Phase and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= PH_IDLE;
            cnt_r   <= ZERO_C;
        end else begin
            phase_r <= phase_s;
            cnt_r   <= cnt_s;
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// Mode sequencer, inactivity timeout and increment demux for the shared
// minute/hour buttons (clock, alarm 0, alarm 1).
module time_set_controller
    import time_set_pkg::*;
#(
    parameter int REPEAT_DELAY = 24,
    parameter int REPEAT_RATE  = 6,
    parameter int TIMEOUT_SEC  = 10
) (
    input  logic       clk_pi,
    input  logic       rst_n_pi,
    input  logic       sec_tick_pi,
    input  logic       rep_tick_pi,
    input  logic       mode_down_pi,
    input  logic       min_down_pi,
    input  logic       hr_down_pi,
    input  logic       min_held_pi,
    input  logic       hr_held_pi,
    output logic [1:0] mode_po,
    output logic       clk_inc_min_po,
    output logic       clk_inc_hr_po,
    output logic       al0_inc_min_po,
    output logic       al0_inc_hr_po,
    output logic       al1_inc_min_po,
    output logic       al1_inc_hr_po,
    output logic       setting_po
);

    localparam int TW = $clog2(TIMEOUT_SEC) + 1;
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT_SEC);
    localparam logic [TW-1:0] TO_SAT_C  = {TW{1'b1}};
    localparam logic [TW-1:0] TO_ONE_C  = TW'(1);
    localparam logic [TW-1:0] TO_ZERO_C = {TW{1'b0}};

    mode_e         mode_r;
    mode_e         mode_s;
    logic          setting_r;
    logic [TW-1:0] to_cnt_r;
    logic [TW-1:0] to_cnt_s;
    logic [TW-1:0] to_inc_s;
    logic          expire_s;
    logic          activity_s;
    logic          flush_s;
    logic          min_evt_s;
    logic          hr_evt_s;
    logic [5:0]    inc_s;
    logic [5:0]    inc_r;

    auto_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_rep_min (
        .clk      (clk_pi),
        .rst_n    (rst_n_pi),
        .press    (min_down_pi),
        .held     (min_held_pi),
        .rep_tick (rep_tick_pi),
        .flush    (flush_s),
        .evt      (min_evt_s)
    );

    auto_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_rep_hr (
        .clk      (clk_pi),
        .rst_n    (rst_n_pi),
        .press    (hr_down_pi),
        .held     (hr_held_pi),
        .rep_tick (rep_tick_pi),
        .flush    (flush_s),
        .evt      (hr_evt_s)
    );

    assign activity_s = min_evt_s || hr_evt_s || mode_down_pi;
    assign to_inc_s   = (to_cnt_r == TO_SAT_C) ? to_cnt_r : (to_cnt_r + TO_ONE_C);
    // Any mode change (press or expiry) sends both repeat engines back to idle.
    assign flush_s    = mode_down_pi || expire_s;

    // Timeout counter and next mode; a mode press clears the count, so it always wins over expiry.
    always_comb begin
        to_cnt_s = to_cnt_r;
        expire_s = 1'b0;
        mode_s   = mode_r;
        if (mode_r == MODE_RUN) begin
            to_cnt_s = TO_ZERO_C;
        end else if (activity_s) begin
            to_cnt_s = TO_ZERO_C;
        end else if (sec_tick_pi) begin
            if (to_inc_s >= TIMEOUT_C) begin
                expire_s = 1'b1;
                to_cnt_s = TO_ZERO_C;
            end else begin
                to_cnt_s = to_inc_s;
            end
        end else begin
            to_cnt_s = to_cnt_r;
        end

        if (mode_down_pi) begin
            mode_s = next_mode(mode_r);
        end else if (expire_s) begin
            mode_s = MODE_RUN;
        end else begin
            mode_s = mode_r;
        end
    end

    // Route this cycle's events to the target selected by the current (pre-advance) mode.
    always_comb begin
        inc_s = 6'b000000;
        case (mode_r)
            MODE_RUN:    inc_s = {min_evt_s, hr_evt_s, 4'b0000};
            MODE_SET_A0: inc_s = {2'b00, min_evt_s, hr_evt_s, 2'b00};
            MODE_SET_A1: inc_s = {4'b0000, min_evt_s, hr_evt_s};
            default:     inc_s = 6'b000000;
        endcase
    end

    // Mode, timeout and output registers.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            mode_r    <= MODE_RUN;
            setting_r <= 1'b0;
            to_cnt_r  <= TO_ZERO_C;
            inc_r     <= 6'b000000;
        end else begin
            mode_r    <= mode_s;
            setting_r <= (mode_s != MODE_RUN);
            to_cnt_r  <= to_cnt_s;
            inc_r     <= inc_s;
        end
    end

    assign mode_po        = mode_r;
    assign setting_po     = setting_r;
    assign clk_inc_min_po = inc_r[5];
    assign clk_inc_hr_po  = inc_r[4];
    assign al0_inc_min_po = inc_r[3];
    assign al0_inc_hr_po  = inc_r[2];
    assign al1_inc_min_po = inc_r[1];
    assign al1_inc_hr_po  = inc_r[0];

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller: a tick-counting reference model
// predicts every output cycle, plus directed pulse-count checks.
module tb_time_set_controller;

    localparam int RD = 24;
    localparam int RR = 6;
    localparam int TO = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sec_tick = 1'b0;
    logic       rep_tick = 1'b0;
    logic       mode_down = 1'b0;
    logic       min_down = 1'b0;
    logic       hr_down = 1'b0;
    logic       min_held = 1'b0;
    logic       hr_held = 1'b0;
    logic [1:0] mode;
    logic       clk_min, clk_hr, al0_min, al0_hr, al1_min, al1_hr, setting;
    logic [8:0] dut_vec;

    int n_checks = 0;
    int n_fail = 0;
    int n_clk_min, n_clk_hr, n_al0_min, n_al0_hr, n_al1_min, n_al1_hr;

    logic [1:0] m_mode;
    int         m_secs;
    logic       m_act_min, m_act_hr;
    int         m_t_min, m_t_hr;
    logic [8:0] sb_q[$];

    time_set_controller #(
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .TIMEOUT_SEC  (TO)
    ) dut (
        .clk_pi         (clk),
        .rst_n_pi       (rst_n),
        .sec_tick_pi    (sec_tick),
        .rep_tick_pi    (rep_tick),
        .mode_down_pi   (mode_down),
        .min_down_pi    (min_down),
        .hr_down_pi     (hr_down),
        .min_held_pi    (min_held),
        .hr_held_pi     (hr_held),
        .mode_po        (mode),
        .clk_inc_min_po (clk_min),
        .clk_inc_hr_po  (clk_hr),
        .al0_inc_min_po (al0_min),
        .al0_inc_hr_po  (al0_hr),
        .al1_inc_min_po (al1_min),
        .al1_inc_hr_po  (al1_hr),
        .setting_po     (setting)
    );

    always #5 clk = ~clk;

    assign dut_vec = {mode, setting, clk_min, clk_hr, al0_min, al0_hr, al1_min, al1_hr};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Ticks-since-press model: strobe on tick RD, then every RR ticks after that.
    task automatic btn_model(input logic d, input logic h, input logic rt,
                             input logic act_i, input int t_i,
                             output logic act_o, output int t_o, output logic ev);
        act_o = act_i;
        t_o   = t_i;
        ev    = 1'b0;
        if (d) begin
            act_o = 1'b1;
            t_o   = 0;
            ev    = 1'b1;
        end else if (!h) begin
            act_o = 1'b0;
            t_o   = 0;
        end else if (act_i && rt) begin
            t_o = t_i + 1;
            if (t_o == RD || (t_o > RD && ((t_o - RD) % RR) == 0)) ev = 1'b1;
        end
    endtask

    task automatic clear_counts();
        n_clk_min = 0; n_clk_hr = 0; n_al0_min = 0;
        n_al0_hr = 0; n_al1_min = 0; n_al1_hr = 0;
    endtask

    task automatic cyc(input logic md, input logic mnd, input logic hrd,
                       input logic st, input logic rt);
        logic       ev_m, ev_h, expire;
        logic [1:0] old;
        logic [8:0] exp_v;
        mode_down = md; min_down = mnd; hr_down = hrd;
        sec_tick = st; rep_tick = rt;
        btn_model(mnd, min_held, rt, m_act_min, m_t_min, m_act_min, m_t_min, ev_m);
        btn_model(hrd, hr_held, rt, m_act_hr, m_t_hr, m_act_hr, m_t_hr, ev_h);
        old = m_mode;
        expire = 1'b0;
        if (m_mode == 2'd0) m_secs = 0;
        else if (ev_m || ev_h || md) m_secs = 0;
        else if (st) begin
            m_secs++;
            if (m_secs == TO) begin
                expire = 1'b1;
                m_secs = 0;
            end
        end
        if (md) m_mode = (m_mode == 2'd2) ? 2'd0 : (m_mode + 2'd1);
        else if (expire) m_mode = 2'd0;
        if (md || expire) begin
            m_act_min = 1'b0;
            m_act_hr  = 1'b0;
        end
        exp_v = {m_mode, (m_mode != 2'd0),
                 (old == 2'd0) && ev_m, (old == 2'd0) && ev_h,
                 (old == 2'd1) && ev_m, (old == 2'd1) && ev_h,
                 (old == 2'd2) && ev_m, (old == 2'd2) && ev_h};
        sb_q.push_back(exp_v);
        @(posedge clk);
        #1;
        check_eq("cyc_out", 32'(dut_vec), 32'(sb_q.pop_front()));
        n_clk_min += int'(clk_min); n_clk_hr += int'(clk_hr);
        n_al0_min += int'(al0_min); n_al0_hr += int'(al0_hr);
        n_al1_min += int'(al1_min); n_al1_hr += int'(al1_hr);
        mode_down = 1'b0; min_down = 1'b0; hr_down = 1'b0;
        sec_tick = 1'b0; rep_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_out", 32'(dut_vec), 32'd0);
        m_mode = 2'd0; m_secs = 0;
        m_act_min = 1'b0; m_act_hr = 1'b0; m_t_min = 0; m_t_hr = 0;
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset and three presses in RUN.
        @(posedge clk);
        #1;
        do_reset();
        clear_counts();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            idle(2);
        end
        check_eq("run_clk_min", 32'(n_clk_min), 32'd3);
        check_eq("run_al_quiet", 32'(n_al0_min + n_al0_hr + n_al1_min + n_al1_hr), 32'd0);

        // Enter SET_A0, press hr.
        clear_counts();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        check_eq("a0_mode", 32'(mode), 32'd1);
        check_eq("a0_setting", 32'(setting), 32'd1);
        check_eq("a0_hr_cnt", 32'(n_al0_hr), 32'd1);
        check_eq("a0_clk_quiet", 32'(n_clk_hr + n_clk_min), 32'd0);

        // SET_A1, hold min for RD + 3*RR ticks.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_counts();
        min_held = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < RD + 3 * RR; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        min_held = 1'b0;
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("a1_rep_cnt", 32'(n_al1_min), 32'd5);
        check_eq("a1_mode", 32'(mode), 32'd2);

        // Back to RUN, then SET_A0 timeout.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < TO; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            idle(1);
        end
        check_eq("timeout_run", 32'(mode), 32'd0);

        // Timeout restarted by a press on tick 9.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 19; i++) begin
            cyc(1'b0, (i == 9), 1'b0, 1'b1, 1'b0);
            idle(1);
            if (i == 10) check_eq("to_tick10", 32'(mode), 32'd1);
        end
        check_eq("to_tick19", 32'(mode), 32'd0);

        // Same-cycle mode + min press in RUN; same-cycle min + hr.
        clear_counts();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("mix_clk_min", 32'(n_clk_min), 32'd1);
        check_eq("mix_mode", 32'(mode), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("both_al0", 32'(n_al0_min + n_al0_hr), 32'd2);

        // SET_A1: mode press coincides with the expiring tick.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < TO - 1; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("mode_vs_expiry", 32'(mode), 32'd0);

        // Reset in the middle of a repeat run in SET_A1.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        min_held = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < RD + RR; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        do_reset();
        clear_counts();
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("post_rst_norep", 32'(n_clk_min + n_al1_min), 32'd0);
        min_held = 1'b0;
        idle(2);

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic md, mnd, hrd;
            md  = ($urandom_range(0, 59) == 0);
            mnd = ($urandom_range(0, 29) == 0);
            hrd = ($urandom_range(0, 29) == 0);
            if (mnd) min_held = 1'b1;
            else if ($urandom_range(0, 39) == 0) min_held = 1'b0;
            if (hrd) hr_held = 1'b1;
            else if ($urandom_range(0, 39) == 0) hr_held = 1'b0;
            cyc(md, mnd, hrd, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/time_set_controller.md
# time_set_controller

Mode sequencer and increment arbiter for the alarm clock's shared minute/hour buttons. It owns the three-way choice of which counter the two adjust buttons drive: the running clock, alarm 0 or alarm 1. It also generates hold-to-repeat increments and drops back to clock mode after a period of inactivity. It sits between the button debouncers and the `clock_fsm` / `alarm_fsm` instances, and tells the top level which time to send to the BCD/display path.

## Interface
Parameters:
- `REPEAT_DELAY`, default 24: `rep_tick_pi` ticks a button must be held before auto-repeat starts (≥1).
- `REPEAT_RATE`, default 6: `rep_tick_pi` ticks between auto-repeat increments (≥1).
- `TIMEOUT_SEC`, default 10: `sec_tick_pi` ticks of inactivity in a set mode before returning to RUN (≥1).

Ports:
- `clk_pi` in 1: system clock.
- `rst_n_pi` in 1: reset, asynchronous, active-low.
- `sec_tick_pi` in 1: one-cycle pulse once per second.
- `rep_tick_pi` in 1: one-cycle periodic pulse, the repeat time base.
- `mode_down_pi` in 1: debounced one-cycle press pulse, mode button.
- `min_down_pi`, `hr_down_pi` in 1 each: debounced one-cycle press pulses.
- `min_held_pi`, `hr_held_pi` in 1 each: debounced held levels of the same buttons.
- `mode_po` out 2: 0 = RUN, 1 = SET_A0, 2 = SET_A1; 3 is never driven.
- `clk_inc_min_po`, `clk_inc_hr_po` out 1 each: increment pulses to `clock_fsm`.
- `al0_inc_min_po`, `al0_inc_hr_po` out 1 each: increment pulses to alarm 0.
- `al1_inc_min_po`, `al1_inc_hr_po` out 1 each: increment pulses to alarm 1.
- `setting_po` out 1: high when `mode_po` ≠ RUN; the top level uses it to select alarm time for the display.

## Operation
- **Reset:**
  - `mode_po` = RUN, `setting_po` = 0.
  - All increment outputs 0.
  - Repeat and timeout counters 0.
- **Mode FSM:**
  - `mode_down_pi` advances RUN → SET_A0 → SET_A1 → RUN.
  - A timeout expiry forces SET_A0 or SET_A1 to RUN.
  - In RUN, the timeout counter is held at 0.
- **Increment events, per button:**
  - The event source is `X_down_pi`, or an auto-repeat strobe for that button.
  - Each event produces exactly one pulse on the output pair selected by the current `mode_po` (RUN → `clk_*`, SET_A0 → `al0_*`, SET_A1 → `al1_*`).
  - The other two targets see 0.
- **Auto-repeat, per button, independent:**
  - On `X_down_pi`, the repeat counter loads 0 and the phase becomes DELAY.
  - While `X_held_pi` = 1, each `rep_tick_pi` increments the counter.
  - In DELAY, when the count reaches `REPEAT_DELAY`: emit a strobe, clear the counter, move to phase REPEAT.
  - In REPEAT, every `REPEAT_RATE` ticks: emit a strobe and clear the counter.
  - `X_held_pi` = 0 returns the phase to IDLE and clears the counter.
- **Timeout:**
  - In a set mode, each `sec_tick_pi` increments the counter.
  - Any min/hr event (press or repeat) or any mode press clears it.
  - When the count reaches `TIMEOUT_SEC`, the mode goes to RUN.
- **Simultaneous events:**
  - min and hr events in the same cycle: both pulses are emitted.
  - Mode press plus an inc event in the same cycle: the inc is routed using the old mode; the mode advances.
  - Mode press in the same cycle as timeout expiry: the mode press wins, normal advance, and the counter clears.
  - Activity in the same cycle as `sec_tick_pi`: the counter clears, and there is no expiry that cycle.
- **Mode change:** both repeat engines return to IDLE. A held button does not repeat into the new target until it is released and pressed again.
- **Coincident press and repeat strobe:** a press pulse and a repeat strobe for the same button in the same cycle produce a single pulse.
- **Width rules:** counter widths are `$clog2` of the relevant parameter plus 1. Counters saturate and never wrap.

## Timing
- Increment outputs are registered: an input pulse in cycle N produces an output pulse in cycle N+1, exactly 1 cycle wide.
- `mode_po` and `setting_po` update in the cycle after `mode_down_pi` or expiry.
- First repeat strobe: its output pulse lands 1 cycle after the `REPEAT_DELAY`-th `rep_tick_pi` following the press. Subsequent strobes follow every `REPEAT_RATE` ticks.
- Reset assertion mid-operation: outputs go to reset values immediately. After deassertion the block resumes in RUN, with no pending strobes.

## Structure
- **Shared package:** `time_set_pkg` holds:
  - the mode encoding constants (`MODE_RUN`, `MODE_SET_A0`, `MODE_SET_A1`);
  - the repeat phase constants (IDLE/DELAY/REPEAT).
- **Sub-module:** `auto_repeat`, instanced twice (min, hr). It takes the press pulse, held level, `rep_tick_pi` and a flush input (driven on mode change), and outputs a combined event pulse.
- **Top of this block:** the mode FSM, the timeout counter and the output demux.

## Test plan
- Reset, then three `min_down_pi` pulses in RUN → three `clk_inc_min_po` pulses, each 1 cycle after its input; `al0_*` and `al1_*` stay 0.
- `mode_down_pi` once, then `hr_down_pi` → `mode_po` = 1, a single `al0_inc_hr_po` pulse, `setting_po` = 1.
- In SET_A1, press min and hold for 24 + 3×6 `rep_tick_pi` ticks → 1 press pulse + 1 delay strobe + 3 repeat strobes = 5 `al1_inc_min_po` pulses; release → no further pulses.
- In SET_A0 with no input, 10 `sec_tick_pi` → `mode_po` returns to 0. Same again but with a `min_down_pi` at tick 9 → still SET_A0 at tick 10, RUN at tick 19.
- Same-cycle `mode_down_pi` + `min_down_pi` in RUN → a `clk_inc_min_po` pulse and `mode_po` = 1. Same-cycle mode press and timeout expiry in SET_A1 → `mode_po` = 0 via normal advance.
- Assert `rst_n_pi` low mid-repeat in SET_A1 → all outputs 0 and `mode_po` = 0 immediately; after release, a still-held button produces no repeats.
